// File: rtl/piso_tx_shifter_pkg.sv
// Shared types and helpers for the PISO serial transmitter.
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_t;

  // The counter is always at least one bit wide, even for single-bit words.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_tx_shifter_if.sv
// Load handshake and serial-side signals of the PISO transmitter.
interface piso_tx_shifter_if #(parameter int WIDTH = 8);

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             sd;
  logic             sd_valid;
  logic             sd_first;
  logic             sd_last;
  logic             busy;

  modport slave (
    input  load_data, load_valid, shift_en,
    output load_ready, sd, sd_valid, sd_first, sd_last, busy
  );

  modport master (
    output load_data, load_valid, shift_en,
    input  load_ready, sd, sd_valid, sd_first, sd_last, busy
  );

endinterface

// File: rtl/piso_tx_shifter_bit_counter.sv
// Bit-position counter: synchronous clear, enable, terminal count at WIDTH-1.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturates at the terminal count; never wraps on its own.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TC_VAL);

endmodule

// File: rtl/piso_tx_shifter.sv
// Parallel-in/serial-out transmitter with valid/ready load and first/last strobes.
//   state | meaning
//   IDLE  | no frame on sd; ready to accept a word
//   SHIFT | driving frame bits; cnt = index of bit currently on sd
module piso_tx_shifter
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               res,
  piso_tx_shifter_if.slave   bus
);

  localparam int CW = cnt_w(WIDTH);

  piso_state_t      state_q;
  piso_state_t      state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  logic [CW-1:0]    cnt;
  logic             tc;
  logic             cnt_clear;
  logic             cnt_en;
  logic             last_en;
  logic             load_ready;
  logic             accept;
  logic             sd_bit;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk    (clk),
    .res    (res),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .cnt    (cnt),
    .tc     (tc)
  );

  // Ready also opens on the last enabled bit so frames can run back-to-back.
  assign last_en    = (state_q == SHIFT) && tc && bus.shift_en;
  assign load_ready = (state_q == IDLE) || last_en;
  assign accept     = bus.load_valid && load_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d   = bus.load_data;
          cnt_clear = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (tc) begin
            cnt_clear = 1'b1;
            if (accept) begin
              shreg_d = bus.load_data;
            end else begin
              shreg_d = '0;
              state_d = IDLE;
            end
          end else begin
            cnt_en  = 1'b1;
            shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  assign sd_bit         = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bus.load_ready = load_ready;
  assign bus.sd         = (state_q == SHIFT) ? sd_bit : 1'b0;
  assign bus.sd_valid   = (state_q == SHIFT);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.sd_first   = (state_q == SHIFT) && (cnt == '0);
  assign bus.sd_last    = (state_q == SHIFT) && tc;

endmodule

// File: tb/tb_piso_tx_shifter.sv
// Directed bench for piso_tx_shifter: MSB-first and LSB-first instances share stimulus.
module tb_piso_tx_shifter;

  localparam int W = 8;

  typedef struct packed {
    logic msb_sd;
    logic lsb_sd;
    logic first;
    logic last;
  } exp_bit_t;

  logic clk = 1'b0;
  logic res = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_bit_t q[$];

  piso_tx_shifter_if #(.WIDTH(W)) bus_m ();
  piso_tx_shifter_if #(.WIDTH(W)) bus_l ();

  piso_tx_shifter #(.WIDTH(W), .MSB_FIRST(1)) dut_m (.clk(clk), .res(res), .bus(bus_m));
  piso_tx_shifter #(.WIDTH(W), .MSB_FIRST(0)) dut_l (.clk(clk), .res(res), .bus(bus_l));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [W-1:0] d, input logic se);
    bus_m.load_valid = lv; bus_m.load_data = d; bus_m.shift_en = se;
    bus_l.load_valid = lv; bus_l.load_data = d; bus_l.shift_en = se;
  endtask

  task automatic chk_outputs(input string tag);
    exp_bit_t e;
    if (q.size() > 0) begin
      e = q[0];
      chk({tag, ":m.sd"}, bus_m.sd, e.msb_sd);
      chk({tag, ":l.sd"}, bus_l.sd, e.lsb_sd);
    end else begin
      e = '0;
      chk({tag, ":m.sd"}, bus_m.sd, 1'b0);
      chk({tag, ":l.sd"}, bus_l.sd, 1'b0);
    end
    chk({tag, ":m.valid"}, bus_m.sd_valid, q.size() > 0);
    chk({tag, ":l.valid"}, bus_l.sd_valid, q.size() > 0);
    chk({tag, ":m.busy"},  bus_m.busy,     q.size() > 0);
    chk({tag, ":m.first"}, bus_m.sd_first, e.first);
    chk({tag, ":l.first"}, bus_l.sd_first, e.first);
    chk({tag, ":m.last"},  bus_m.sd_last,  e.last);
    chk({tag, ":l.last"},  bus_l.sd_last,  e.last);
  endtask

  // One clock: drive at negedge, check ready, update scoreboard, check outputs next negedge.
  task automatic cycle(input string tag, input logic lv, input logic [W-1:0] d, input logic se);
    logic exp_ready;
    drive(lv, d, se);
    #1;
    exp_ready = (q.size() == 0) || ((q.size() == 1) && se);
    chk({tag, ":m.ready"}, bus_m.load_ready, exp_ready);
    chk({tag, ":l.ready"}, bus_l.load_ready, exp_ready);
    if ((q.size() > 0) && se) void'(q.pop_front());
    if (lv && exp_ready) begin
      for (int i = 0; i < W; i++) begin
        q.push_back('{msb_sd: d[W-1-i], lsb_sd: d[i], first: (i == 0), last: (i == W-1)});
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    drive(1'b0, '0, 1'b0);
    res = 1'b0;
    #1;
    q.delete();
    chk({tag, ":rst.m.sd"},    bus_m.sd,       1'b0);
    chk({tag, ":rst.l.sd"},    bus_l.sd,       1'b0);
    chk({tag, ":rst.m.valid"}, bus_m.sd_valid, 1'b0);
    chk({tag, ":rst.m.busy"},  bus_m.busy,     1'b0);
    chk({tag, ":rst.m.first"}, bus_m.sd_first, 1'b0);
    chk({tag, ":rst.m.last"},  bus_m.sd_last,  1'b0);
    @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    #1;
    chk({tag, ":rel.m.ready"}, bus_m.load_ready, 1'b1);
    chk({tag, ":rel.l.ready"}, bus_l.load_ready, 1'b1);
    chk({tag, ":rel.m.valid"}, bus_m.sd_valid,   1'b0);
  endtask

  initial begin
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    do_reset("init");

    // single word, full-rate
    cycle("a5", 1'b1, 8'hA5, 1'b1);
    for (int k = 0; k < W + 2; k++) cycle("a5", 1'b0, W'($urandom), 1'b1);

    // single set bit: LSB instance emits 1 then zeros
    cycle("01", 1'b1, 8'h01, 1'b1);
    for (int k = 0; k < W + 2; k++) cycle("01", 1'b0, W'($urandom), 1'b1);

    // back-to-back with valid held
    cycle("b2b", 1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < W; k++) cycle("b2b", 1'b1, 8'h00, 1'b1);
    for (int k = 0; k < W + 2; k++) cycle("b2b", 1'b0, W'($urandom), 1'b1);

    // stalls: shift_en pattern 1,0,0,1,0,0...
    cycle("stall", 1'b1, 8'h5A, 1'b1);
    for (int k = 1; k < 3 * W + 4; k++) cycle("stall", 1'b0, W'($urandom), (k % 3) == 0);

    // reset mid-frame then a fresh word
    cycle("mid", 1'b1, 8'hC3, 1'b1);
    for (int k = 0; k < 3; k++) cycle("mid", 1'b0, 8'hC3, 1'b1);
    do_reset("mid");
    cycle("3c", 1'b1, 8'h3C, 1'b1);
    for (int k = 0; k < W + 2; k++) cycle("3c", 1'b0, W'($urandom), 1'b1);

    // mixed random traffic
    for (int k = 0; k < 120; k++) begin
      cycle("rnd", 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
